// File: rtl/pipe_pkg.sv
// pipe_pkg: shared payload types, occupancy state and helpers for CPU pipeline stage buffers
package pipe_pkg;
   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        we;
   } mw_payload_t;
   typedef struct packed {
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [3:0]  alu_op;
      logic [4:0]  rd;
      logic        we;
   } ex_payload_t;
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
   function automatic int clog2_occ(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/pipe_ptr.sv
// pipe_ptr: wrap-around index 0..Depth-1 with increment and synchronous clear
module pipe_ptr #(
   parameter int Depth = 2,
   localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            inc_i,
   input  logic            clr_i,
   output logic [PtrW-1:0] ptr_o
);
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) ptr_o <= '0;
      else if (clr_i) ptr_o <= '0;
      else if (inc_i) ptr_o <= (ptr_o == PtrW'(Depth - 1)) ? '0 : ptr_o + 1'b1;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready circular-buffer pipeline stage with synchronous flush.
// Define PIPE_STAGE_BUF_PERF_EN to add the saturating back-pressure counter stall_cnt_o.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DataWidth        = 32,
   parameter int Depth            = 2,
   parameter bit FallThroughReady = 1'b0,
   parameter bit ClearDataOnReset = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       flush_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [DataWidth-1:0]       data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DataWidth-1:0]       data_o,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
`ifdef PIPE_STAGE_BUF_PERF_EN
   ,
   output logic [31:0]                stall_cnt_o
`endif
);
   localparam int CntW = clog2_occ(Depth);
   localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
   logic [DataWidth-1:0] mem [Depth];
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [CntW-1:0] count;
   logic push, pop;
   state_t state;
   assign state   = (count == '0) ? EMPTY : (count == CntW'(Depth)) ? FULL : PARTIAL;
   assign empty_o = state == EMPTY;
   assign full_o  = state == FULL;
   assign count_o = count;
   assign valid_o = !empty_o;
   // Fall-through lets a full stage accept while its head leaves, at the cost of a comb ready path
   assign ready_o = FallThroughReady ? (!full_o || ready_i) : !full_o;
   assign push    = valid_i && ready_o && !flush_i;
   assign pop     = valid_o && ready_i && !flush_i;
   assign data_o  = mem[rd_ptr];
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) count <= '0;
      else if (flush_i) count <= '0;
      else if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
   if (ClearDataOnReset) begin : g_clr
      always_ff @(posedge clk_i or negedge reset_ni)
         if (!reset_ni) for (int i = 0; i < Depth; i++) mem[i] <= '0;
         else if (push) mem[wr_ptr] <= data_i;
   end else begin : g_noclr
      always_ff @(posedge clk_i)
         if (push) mem[wr_ptr] <= data_i;
   end
   pipe_ptr #(.Depth(Depth)) u_wr_ptr (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .inc_i   (push),
      .clr_i   (flush_i),
      .ptr_o   (wr_ptr)
   );
   pipe_ptr #(.Depth(Depth)) u_rd_ptr (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .inc_i   (pop),
      .clr_i   (flush_i),
      .ptr_o   (rd_ptr)
   );
`ifdef PIPE_STAGE_BUF_PERF_EN
   logic [1:0] stall_inc;
   assign stall_inc = {1'b0, valid_o && !ready_i} + {1'b0, valid_i && !ready_o};
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) stall_cnt_o <= '0;
      else if (stall_cnt_o > 32'hFFFF_FFFF - 32'(stall_inc)) stall_cnt_o <= '1;
      else stall_cnt_o <= stall_cnt_o + 32'(stall_inc);
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench over three stage configurations (D2/FTR0, D1/FTR1, D3/FTR0)
module tb_pipe_stage_buf;
   logic clk_i = 1'b0, reset_ni = 1'b0;
   always #5 clk_i = ~clk_i;
   int compared = 0, mismatched = 0;
   logic [7:0] q_a[$], q_b[$], q_c[$];
   logic fl_a = 0, vi_a = 0, ri_a = 0, ro_a, vo_a, full_a, empty_a;
   logic [7:0] di_a = 0, do_a;
   logic [1:0] cnt_a;
   logic fl_b = 0, vi_b = 0, ri_b = 0, ro_b, vo_b, full_b, empty_b;
   logic [7:0] di_b = 0, do_b;
   logic [0:0] cnt_b;
   logic fl_c = 0, vi_c = 0, ri_c = 0, ro_c, vo_c, full_c, empty_c;
   logic [7:0] di_c = 0, do_c;
   logic [1:0] cnt_c;
`ifdef PIPE_STAGE_BUF_PERF_EN
   logic [31:0] st_a, st_b, st_c;
`endif
   pipe_stage_buf #(.DataWidth(8), .Depth(2), .FallThroughReady(0), .ClearDataOnReset(1)) u_a (
      .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(fl_a), .valid_i(vi_a), .ready_o(ro_a),
      .data_i(di_a), .valid_o(vo_a), .ready_i(ri_a), .data_o(do_a), .count_o(cnt_a),
      .full_o(full_a), .empty_o(empty_a)
`ifdef PIPE_STAGE_BUF_PERF_EN
      , .stall_cnt_o(st_a)
`endif
   );
   pipe_stage_buf #(.DataWidth(8), .Depth(1), .FallThroughReady(1), .ClearDataOnReset(0)) u_b (
      .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(fl_b), .valid_i(vi_b), .ready_o(ro_b),
      .data_i(di_b), .valid_o(vo_b), .ready_i(ri_b), .data_o(do_b), .count_o(cnt_b),
      .full_o(full_b), .empty_o(empty_b)
`ifdef PIPE_STAGE_BUF_PERF_EN
      , .stall_cnt_o(st_b)
`endif
   );
   pipe_stage_buf #(.DataWidth(8), .Depth(3), .FallThroughReady(0), .ClearDataOnReset(0)) u_c (
      .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(fl_c), .valid_i(vi_c), .ready_o(ro_c),
      .data_i(di_c), .valid_o(vo_c), .ready_i(ri_c), .data_o(do_c), .count_o(cnt_c),
      .full_o(full_c), .empty_o(empty_c)
`ifdef PIPE_STAGE_BUF_PERF_EN
      , .stall_cnt_o(st_c)
`endif
   );
   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction
   function automatic void unexpected(string name, logic [7:0] act);
      compared++;
      mismatched++;
      $display("FAIL %s: got data_o=%0h while nothing was expected", name, act);
   endfunction
   // Monitors: a transfer happens at the next rising edge whenever valid_o & ready_i & !flush_i
   always @(negedge clk_i)
      if (reset_ni && vo_a && ri_a && !fl_a) begin
         if (q_a.size() == 0) unexpected("a_out", do_a);
         else check("a_data", {24'h0, do_a}, {24'h0, q_a.pop_front()});
      end
   always @(negedge clk_i)
      if (reset_ni && vo_b && ri_b && !fl_b) begin
         if (q_b.size() == 0) unexpected("b_out", do_b);
         else check("b_data", {24'h0, do_b}, {24'h0, q_b.pop_front()});
      end
   always @(negedge clk_i)
      if (reset_ni && vo_c && ri_c && !fl_c) begin
         if (q_c.size() == 0) unexpected("c_out", do_c);
         else check("c_data", {24'h0, do_c}, {24'h0, q_c.pop_front()});
      end
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask
   initial begin
      repeat (2) tick;
      check("rst_valid", vo_a, 0);
      check("rst_count", cnt_a, 0);
      check("rst_ready", ro_a, 1);
      check("rst_empty", empty_a, 1);
      check("rst_full", full_a, 0);
      check("rst_data", do_a, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
      check("rst_stall", st_a, 0);
`endif
      reset_ni = 1;
      tick;
      // fill D2 with back-pressure, then drain
      ri_a = 0; vi_a = 1; di_a = 8'h0A; q_a.push_back(8'h0A);
      tick;
      di_a = 8'h0B; q_a.push_back(8'h0B);
      tick;
      di_a = 8'h0C;
      check("full_flag", full_a, 1);
      check("full_ready", ro_a, 0);
      check("full_head", do_a, 8'h0A);
      check("full_count", cnt_a, 2);
      tick;
      check("full_hold_count", cnt_a, 2);
      check("full_hold_head", do_a, 8'h0A);
      vi_a = 0; ri_a = 1;
      tick;
      tick;
      check("drain_empty", empty_a, 1);
      check("drain_count", cnt_a, 0);
      // streaming with one-cycle lag
      vi_a = 1;
      for (int i = 1; i <= 8; i++) begin
         di_a = 8'(i); q_a.push_back(8'(i));
         tick;
         check("stream_count", cnt_a, 1);
      end
      vi_a = 0;
      tick;
      check("stream_end_count", cnt_a, 0);
      // async reset mid-stream drops both entries
      ri_a = 0; vi_a = 1; di_a = 8'h11;
      tick;
      di_a = 8'h22;
      tick;
      vi_a = 0;
      check("pre_rst_count", cnt_a, 2);
      #2 reset_ni = 0;
      #1;
      q_a.delete();
      check("mid_rst_valid", vo_a, 0);
      check("mid_rst_count", cnt_a, 0);
      check("mid_rst_ready", ro_a, 1);
      check("mid_rst_data", do_a, 0);
      tick;
      reset_ni = 1;
      tick;
      // back-pressure stall then flush
      vi_a = 1; di_a = 8'h33; q_a.push_back(8'h33);
      tick;
      vi_a = 0;
      repeat (10) tick;
`ifdef PIPE_STAGE_BUF_PERF_EN
      check("stall_cnt", st_a, 10);
`endif
      fl_a = 1; ri_a = 1; q_a.delete();
      tick;
      fl_a = 0;
      tick;
      check("a_flush_count", cnt_a, 0);
      check("a_flush_valid", vo_a, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
      check("stall_after_flush", st_a, 10);
`endif
      // D1 fall-through: simultaneous pop and push while full
      vi_b = 1; di_b = 8'h05; q_b.push_back(8'h05);
      tick;
      vi_b = 0;
      check("b_full", full_b, 1);
      check("b_ready_blocked", ro_b, 0);
      ri_b = 1; vi_b = 1; di_b = 8'h06;
      #1;
      check("b_ready_ft", ro_b, 1);
      q_b.push_back(8'h06);
      tick;
      vi_b = 0;
      check("b_count", cnt_b, 1);
      check("b_head", do_b, 8'h06);
      tick;
      check("b_empty", empty_b, 1);
      ri_b = 0;
      // D3 flush drops contents and the flush-cycle input
      vi_c = 1; di_c = 8'h21; q_c.push_back(8'h21);
      tick;
      di_c = 8'h22; q_c.push_back(8'h22);
      tick;
      check("c_pre_flush_count", cnt_c, 2);
      fl_c = 1; di_c = 8'h23; ri_c = 1; q_c.delete();
      tick;
      fl_c = 0; vi_c = 0;
      check("c_flush_count", cnt_c, 0);
      check("c_flush_valid", vo_c, 0);
      check("c_flush_ready", ro_c, 1);
      // wrap: two resident entries, then seven push/pop pairs
      ri_c = 0; vi_c = 1;
      di_c = 8'h30; q_c.push_back(8'h30);
      tick;
      di_c = 8'h31; q_c.push_back(8'h31);
      tick;
      ri_c = 1;
      for (int i = 0; i < 7; i++) begin
         di_c = 8'h40 + 8'(i); q_c.push_back(8'h40 + 8'(i));
         tick;
         check("c_wrap_count", cnt_c, 2);
      end
      vi_c = 0;
      tick;
      tick;
      check("c_drain_empty", empty_c, 1);
      repeat (2) tick;
      check("a_left", q_a.size(), 0);
      check("b_left", q_b.size(), 0);
      check("c_left", q_c.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
